// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage / loader requesters, the arbiter and the
// single-port data memory.
interface dmem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic        a_stall;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_lock;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_lock, b_we, b_addr, b_wdata,
    input  mem_dataout,
    output a_ack, a_stall, a_rdata,
    output b_ack, b_rdata,
    output mem_we, mem_addr, mem_datain
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_lock, b_we, b_addr, b_wdata,
    output mem_dataout,
    input  a_ack, a_stall, a_rdata,
    input  b_ack, b_rdata,
    input  mem_we, mem_addr, mem_datain
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: pipeline (A) has priority,
// loader (B) gets starvation protection and capped locked bursts.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);
  localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);
  localparam bit         LP_BURST_EN = (MAX_LOCK > 1);

  typedef enum logic {ARB, BLOCK} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;
  logic [7:0] r_lock_cnt;
  logic [7:0] w_lock_nxt;
  logic [7:0] w_lock_inc;
  logic       w_force_b;
  logic       w_gnt_a;
  logic       w_gnt_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_wait_cnt <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  // Grant is a pure function of current requests and registered state, so
  // acks and memory controls are valid in the same cycle as the request.
  always_comb begin
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    w_lock_inc  = r_lock_cnt + 8'd1;
    w_force_b   = bus.b_req && (r_wait_cnt >= LP_MAX_WAIT);

    unique case (r_state)
      ARB: begin
        w_gnt_b    = w_force_b || (bus.b_req && !bus.a_req);
        w_gnt_a    = bus.a_req && !w_gnt_b;
        w_lock_nxt = '0;
        if (w_gnt_b && bus.b_lock && LP_BURST_EN) begin
          w_state_nxt = BLOCK;
          w_lock_nxt  = 8'd1;
        end
      end
      BLOCK: begin
        w_gnt_b = bus.b_req;
        // Cap exit wins over b_lock so the pipeline is never held indefinitely.
        if (!bus.b_req || !bus.b_lock || (w_lock_inc >= LP_MAX_LOCK)) begin
          w_state_nxt = ARB;
          w_lock_nxt  = '0;
        end else begin
          w_lock_nxt  = w_lock_inc;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_lock_nxt  = '0;
      end
    endcase

    if (w_gnt_b || !bus.b_req) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != 8'hFF) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end else begin
      w_wait_nxt = r_wait_cnt;
    end
  end

  always_comb begin
    bus.a_ack      = w_gnt_a;
    bus.b_ack      = w_gnt_b;
    bus.a_stall    = bus.a_req && !w_gnt_a;
    bus.a_rdata    = w_gnt_a ? bus.mem_dataout : '0;
    bus.b_rdata    = w_gnt_b ? bus.mem_dataout : '0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_datain = '0;
    if (w_gnt_a) begin
      bus.mem_we     = bus.a_we;
      bus.mem_addr   = bus.a_addr;
      bus.mem_datain = bus.a_wdata;
    end else if (w_gnt_b) begin
      bus.mem_we     = bus.b_we;
      bus.mem_addr   = bus.b_addr;
      bus.mem_datain = bus.b_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural 32x32 memory
// preloaded so that word i holds the value i.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  logic [31:0] mem [32];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_WAIT(4), .MAX_LOCK(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 32; i++) mem[i] <= i;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[6:2]] <= bus.mem_datain;
    end
  end

  assign bus.mem_dataout = mem[bus.mem_addr[6:2]];

  typedef struct {
    string       name;
    logic        r;
    logic        ar, aw;
    logic [31:0] aa, ad;
    logic        br, bl, bw;
    logic [31:0] ba, bd;
    logic        ea, es;
    logic [31:0] ear;
    logic        eb;
    logic [31:0] ebr;
    logic        ew;
    logic [31:0] ema;
  } vec_t;

  function automatic vec_t mk(string n, logic r,
                              logic ar, logic aw, logic [31:0] aa, logic [31:0] ad,
                              logic br, logic bl, logic bw, logic [31:0] ba, logic [31:0] bd,
                              logic ea, logic es, logic [31:0] ear,
                              logic eb, logic [31:0] ebr, logic ew, logic [31:0] ema);
    vec_t v;
    v.name = n; v.r = r;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bl = bl; v.bw = bw; v.ba = ba; v.bd = bd;
    v.ea = ea; v.es = es; v.ear = ear; v.eb = eb; v.ebr = ebr;
    v.ew = ew; v.ema = ema;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [99:0] got, exp;
    @(negedge clk);
    rst         = v.r;
    bus.a_req   = v.ar; bus.a_we = v.aw; bus.a_addr = v.aa; bus.a_wdata = v.ad;
    bus.b_req   = v.br; bus.b_lock = v.bl; bus.b_we = v.bw;
    bus.b_addr  = v.ba; bus.b_wdata = v.bd;
    #2;
    got = {bus.a_ack, bus.a_stall, bus.b_ack, bus.mem_we,
           bus.a_rdata, bus.b_rdata, bus.mem_addr};
    exp = {v.ea, v.es, v.eb, v.ew, v.ear, v.ebr, v.ema};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got a_ack=%b a_stall=%b b_ack=%b mem_we=%b a_rdata=%h b_rdata=%h mem_addr=%h; want a_ack=%b a_stall=%b b_ack=%b mem_we=%b a_rdata=%h b_rdata=%h mem_addr=%h",
               v.name, bus.a_ack, bus.a_stall, bus.b_ack, bus.mem_we,
               bus.a_rdata, bus.b_rdata, bus.mem_addr,
               v.ea, v.es, v.eb, v.ew, v.ear, v.ebr, v.ema);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100us");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    bit   bgnt;
    logic ar;

    //                  name               r  ar aw aa      ad            br bl bw ba      bd            ea es ear           eb ebr           ew ema
    tbl.push_back(mk("reset_idle",       1, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00));
    tbl.push_back(mk("a_rd_08",          0, 1, 0, 32'h08, 32'h0,        0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h2,        0, 32'h0,        0, 32'h08));
    tbl.push_back(mk("a_wr_0c",          0, 1, 1, 32'h0C, 32'hDEADBEEF, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h3,        0, 32'h0,        1, 32'h0C));
    tbl.push_back(mk("b_rd_0c",          0, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h0C, 32'h0,        0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0C));
    tbl.push_back(mk("idle_no_drive",    0, 0, 1, 32'h44, 32'h55AA55AA, 0, 0, 1, 32'h48, 32'h0F0F0F0F, 0, 0, 32'h0,        0, 32'h0,        0, 32'h00));
    tbl.push_back(mk("b_wr_14",          0, 0, 0, 32'h00, 32'h0,        1, 0, 1, 32'h14, 32'h12345678, 0, 0, 32'h0,        1, 32'h5,        1, 32'h14));
    tbl.push_back(mk("a_rd_14",          0, 1, 0, 32'h14, 32'h0,        0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h12345678, 0, 32'h0,        0, 32'h14));
    tbl.push_back(mk("a_wr_0c_restore",  0, 1, 1, 32'h0C, 32'h3,        0, 0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h0,        1, 32'h0C));
    tbl.push_back(mk("burst_04",         0, 0, 0, 32'h00, 32'h0,        1, 1, 0, 32'h04, 32'h0,        0, 0, 32'h0,        1, 32'h1,        0, 32'h04));
    tbl.push_back(mk("burst_08_astall",  0, 1, 0, 32'h10, 32'h0,        1, 1, 0, 32'h08, 32'h0,        0, 1, 32'h0,        1, 32'h2,        0, 32'h08));
    tbl.push_back(mk("burst_0c_astall",  0, 1, 0, 32'h10, 32'h0,        1, 1, 0, 32'h0C, 32'h0,        0, 1, 32'h0,        1, 32'h3,        0, 32'h0C));
    tbl.push_back(mk("burst_10_last",    0, 1, 0, 32'h10, 32'h0,        1, 0, 0, 32'h10, 32'h0,        0, 1, 32'h0,        1, 32'h4,        0, 32'h10));
    tbl.push_back(mk("a_after_burst",    0, 1, 0, 32'h10, 32'h0,        0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h4,        0, 32'h0,        0, 32'h10));
    tbl.push_back(mk("rst_pre_idle",     0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00));
    tbl.push_back(mk("rst_burst_start",  0, 0, 0, 32'h00, 32'h0,        1, 1, 0, 32'h28, 32'h0,        0, 0, 32'h0,        1, 32'hA,        0, 32'h28));
    tbl.push_back(mk("rst_mid_burst",    1, 1, 0, 32'h30, 32'h0,        1, 1, 0, 32'h2C, 32'h0,        0, 1, 32'h0,        1, 32'hB,        0, 32'h2C));
    tbl.push_back(mk("rst_release_a",    0, 1, 0, 32'h30, 32'h0,        1, 1, 0, 32'h2C, 32'h0,        1, 0, 32'hC,        0, 32'h0,        0, 32'h30));
    tbl.push_back(mk("rst_post_idle",    0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h00));

    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_lock = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Both ports requesting continuously: B forced in on every 5th cycle.
    for (int unsigned k = 1; k <= 10; k++) begin
      bgnt = (k == 5) || (k == 10);
      apply(mk($sformatf("starve_%0d", k), 0,
               1, 0, 32'h18, 32'h0, 1, 0, 0, 32'h1C, 32'h0,
               !bgnt, bgnt, bgnt ? 32'h0 : 32'h6,
               bgnt, bgnt ? 32'h7 : 32'h0, 0, bgnt ? 32'h1C : 32'h18));
    end

    // Locked burst opened while A is idle, then A waits behind the 8-grant cap.
    for (int unsigned k = 0; k <= 8; k++) begin
      ar   = (k != 0);
      bgnt = (k < 8);
      apply(mk($sformatf("lockcap_%0d", k), 0,
               ar, 0, 32'h24, 32'h0, 1, 1, 0, 32'h20, 32'h0,
               !bgnt, ar && bgnt, bgnt ? 32'h0 : 32'h9,
               bgnt, bgnt ? 32'h8 : 32'h0, 0, bgnt ? 32'h20 : 32'h24));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32x32 data memory between two requesters.
  - Port A: pipeline MEM stage. Has priority.
  - Port B: debug/loader engine. Supports locked bursts.
- Memory read is combinational and write is on the posedge, so each granted access completes in the cycle it is granted.
- Port B is protected by a starvation counter; the pipeline is protected by a burst-length cap.
- The block sits between the MEM stage and the memory instance. It drives the memory's `we`/`addr`/`datain` and returns `dataout`.

Parameters:
- `MAX_WAIT`, 4: consecutive denied cycles after which B is forced ahead of A. Range 1..255.
- `MAX_LOCK`, 8: maximum B grants in one locked burst. Range 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `a_req`  in  1  MEM stage requests an access this cycle.
- `a_we`  in  1  A access is a write.
- `a_addr`  in  32  A byte address; memory uses `[6:2]`.
- `a_wdata`  in  32  A write data.
- `a_ack`  out  1  A access performed this cycle.
- `a_stall`  out  1  `a_req & ~a_ack`; holds the pipeline.
- `a_rdata`  out  32  read data for A; valid when `a_ack`.
- `b_req`  in  1  loader requests an access.
- `b_lock`  in  1  keep grant after this access (burst continues).
- `b_we`  in  1  B access is a write.
- `b_addr`  in  32  B byte address.
- `b_wdata`  in  32  B write data.
- `b_ack`  out  1  B access performed this cycle.
- `b_rdata`  out  32  read data for B; valid when `b_ack`.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  32  to memory `addr`.
- `mem_datain`  out  32  to memory `datain`.
- `mem_dataout`  in  32  from memory `dataout` (combinational).

Behaviour:
- **Registered state:**
  - `state` ∈ {ARB, BLOCK}.
  - `wait_cnt[7:0]`: consecutive cycles B was requesting and denied.
  - `lock_cnt[7:0]`: B grants taken in the current BLOCK.
- **Grant decision:** combinational from the current requests and registered state. Acks, memory controls and `rdata` are therefore zero-latency.
- **ARB state:**
  - `force_b = b_req & (wait_cnt >= MAX_WAIT)`.
  - B is granted if `force_b`, or if `b_req & ~a_req`.
  - Otherwise A is granted if `a_req`.
  - Otherwise nothing is granted.
- **BLOCK state:**
  - B is granted if `b_req`. A is never granted.
  - If `~b_req`, nothing is granted and the state returns to ARB.
- **Transitions, evaluated at posedge:**
  - ARB→BLOCK when B is granted with `b_lock=1` and `MAX_LOCK > 1`. `lock_cnt` is set to 1.
  - In BLOCK, each B grant increments `lock_cnt`.
  - BLOCK→ARB when any of these holds:
    - B is granted with `b_lock=0`;
    - `b_req=0`;
    - the grant brings `lock_cnt` to `MAX_LOCK`.
  - The cap exit is forced even if `b_lock` stays high.
  - On any return to ARB, `lock_cnt` is cleared.
- **wait_cnt:**
  - Cleared on a B grant or when `b_req=0`.
  - Incremented when `b_req` is high and B is not granted, saturating at 255.
- **Memory drive:**
  - When X is granted: `mem_addr=X_addr`, `mem_datain=X_wdata`, `mem_we=X_we`.
  - When nothing is granted: all three are 0. `mem_we` is never high without an ack.
- **Read data:** `a_rdata = a_ack ? mem_dataout : 0`; `b_rdata = b_ack ? mem_dataout : 0`.
- **Ack exclusivity:** `a_ack` and `b_ack` are never both 1.
- **A write during the cycle:** the memory commits it at the posedge ending the cycle. A read of the same word in the next cycle returns the new value.
- **Reset:**
  - `state=ARB`, `wait_cnt=0`, `lock_cnt=0`.
  - With no requests, every output is 0.
  - Reset asserted mid-burst aborts BLOCK. The cycle after reset releases arbitrates from ARB.
  - Reset does not gate that cycle's combinational grant. Memory contents are not touched by reset.
- **Simultaneous requests:**
  - Same cycle, normal case: A wins and `wait_cnt` increments.
  - When `force_b` and `a_req` are both true, B wins and A stalls exactly that cycle.

Test Plan:
- After reset, `a_req=1`, `a_we=0`, `a_addr=0x08` → same cycle `a_ack=1`, `a_rdata=0x00000002`, `mem_we=0`, `a_stall=0`, `b_ack=0`.
- `a_req` write `a_addr=0x0C`, `a_wdata=0xDEADBEEF`; next cycle `b_req` read `b_addr=0x0C` with `a_req=0` → `b_ack=1`, `b_rdata=0xDEADBEEF`.
- `a_req` and `b_req` held high continuously, `MAX_WAIT=4` → A acked cycles 1–4, B acked cycle 5 (`a_stall=1` there), A cycles 6–9, B cycle 10; `wait_cnt` returns to 0 after each B ack.
- `a_req=0`; B reads `0x04,0x08,0x0C` with `b_lock=1`, then `0x10` with `b_lock=0` → `b_rdata` = 1,2,3,4 on consecutive cycles. Raising `a_req` during the burst keeps `a_stall=1` until the cycle after the `0x10` access.
- `b_lock` held high with `b_req` and `a_req` high, `MAX_LOCK=8` → exactly 8 consecutive `b_ack`, then `a_ack=1` on the 9th cycle.
- Assert `rst` for one cycle during a locked burst, with `a_req` and `b_req` still high afterwards → after release the state is ARB, and `a_ack=1` in the first post-reset cycle (`wait_cnt=0`).
